// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the bus arbiter
package bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT_WAIT = 3'd1,
    ST_BUSY       = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_ABORT      = 3'd4
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDW         = clog2_safe(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDW-1:0]         last,
  output logic                   found,
  output logic [IDW-1:0]         idx
);

  logic [IDW-1:0] cand;

  // Search starts one past the previous winner and wraps; the previous winner is tried last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDW'((int'(last) + k) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin grant sequencer with acceptance timeout and hold limit
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT_LEN = 6,
  parameter int HOLD_LEN    = 12,
  parameter int IDW         = clog2_safe(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_request,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic                   b_util,
  output logic                   arbiter_cmd_out,
  output logic [IDW-1:0]         owner_id,
  output logic                   bus_busy,
  output logic [2:0]             arb_state
);

  localparam int TW = (TIMEOUT_LEN > HOLD_LEN) ? TIMEOUT_LEN : HOLD_LEN;
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'({TIMEOUT_LEN{1'b1}});
  localparam logic [TW-1:0] HOLD_MAX    = TW'({HOLD_LEN{1'b1}});

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   cmd_q, cmd_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   busy_q, busy_d;

  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDW        (IDW)
  ) u_rr_pick (
    .req  (m_request),
    .last (last_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = 1'b0;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = NUM_MASTERS'(1) << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          state_d = ST_GRANT_WAIT;
        end
      end
      ST_GRANT_WAIT: begin
        if (b_util) begin
          state_d = ST_BUSY;
        end else if (!m_request[owner_q]) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (timer_q == TIMEOUT_MAX) begin
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BUSY: begin
        if (!b_util) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (timer_q == HOLD_MAX) begin
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ABORT: begin
        grant_d = '0;
        cmd_d   = 1'b1;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    // The shared timer restarts on every state change.
    if (state_d != state_q) begin
      timer_d = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cmd_q   <= 1'b0;
      owner_q <= '0;
      last_q  <= IDW'(NUM_MASTERS - 1);
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
    end
  end

  assign m_grant         = grant_q;
  assign arbiter_cmd_out = cmd_q;
  assign owner_id        = owner_q;
  assign bus_busy        = busy_q;
  assign arb_state       = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] m_request;
  logic [3:0] m_grant;
  logic       b_util;
  logic       arbiter_cmd_out;
  logic [1:0] owner_id;
  logic       bus_busy;
  logic [2:0] arb_state;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(
    .NUM_MASTERS(4),
    .TIMEOUT_LEN(6),
    .HOLD_LEN   (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .m_request      (m_request),
    .m_grant        (m_grant),
    .b_util         (b_util),
    .arbiter_cmd_out(arbiter_cmd_out),
    .owner_id       (owner_id),
    .bus_busy       (bus_busy),
    .arb_state      (arb_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    m_request = 4'b0000;
    b_util    = 1'b0;
    step(2);
    chk("rst_grant", 32'(m_grant), 32'h0);
    chk("rst_cmd",   32'(arbiter_cmd_out), 32'h0);
    chk("rst_owner", 32'(owner_id), 32'h0);
    chk("rst_busy",  32'(bus_busy), 32'h0);
    chk("rst_state", 32'(arb_state), 32'h0);
    rstn = 1'b1;

    // Single request from master 2, normal transfer.
    m_request = 4'b0100;
    step(1);
    chk("t1_grant", 32'(m_grant), 32'h4);
    chk("t1_owner", 32'(owner_id), 32'h2);
    chk("t1_state", 32'(arb_state), 32'h1);
    chk("t1_busy",  32'(bus_busy), 32'h1);
    b_util = 1'b1;
    step(1);
    chk("t1_busy_state", 32'(arb_state), 32'h2);
    m_request = 4'b0000;
    step(9);
    chk("t1_hold_state", 32'(arb_state), 32'h2);
    chk("t1_hold_grant", 32'(m_grant), 32'h4);
    b_util = 1'b0;
    step(1);
    chk("t1_rel_state", 32'(arb_state), 32'h3);
    chk("t1_rel_grant", 32'(m_grant), 32'h0);
    step(1);
    chk("t1_idle_state", 32'(arb_state), 32'h0);
    chk("t1_idle_busy",  32'(bus_busy), 32'h0);
    chk("t1_idle_cmd",   32'(arbiter_cmd_out), 32'h0);

    // Fairness with all masters requesting; reset restores master 0 priority.
    rstn      = 1'b0;
    m_request = 4'b1111;
    step(1);
    rstn = 1'b1;
    step(1);
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(m_grant), 32'(4'b0001 << (k % 4)));
      chk("rr_owner", 32'(owner_id), 32'(k % 4));
      b_util = 1'b1;
      step(5);
      chk("rr_held", 32'(m_grant), 32'(4'b0001 << (k % 4)));
      b_util = 1'b0;
      step(1);
      chk("rr_rel_grant", 32'(m_grant), 32'h0);
      chk("rr_rel_state", 32'(arb_state), 32'h3);
      step(1);
      chk("rr_idle_state", 32'(arb_state), 32'h0);
      step(1);
    end

    // Master 1 now in GRANT_WAIT; withdrawing releases without abort.
    m_request = 4'b0000;
    step(1);
    chk("wd_grant", 32'(m_grant), 32'h0);
    chk("wd_state", 32'(arb_state), 32'h3);
    chk("wd_cmd",   32'(arbiter_cmd_out), 32'h0);
    chk("wd_owner", 32'(owner_id), 32'h1);
    step(1);
    chk("wd_idle", 32'(arb_state), 32'h0);
    chk("wd_cmd2", 32'(arbiter_cmd_out), 32'h0);

    // Grant-acceptance timeout: pulse 65 edges after the grant edge.
    m_request = 4'b0010;
    step(1);
    chk("to_grant", 32'(m_grant), 32'h2);
    step(64);
    chk("to_pre_state", 32'(arb_state), 32'h4);
    chk("to_pre_cmd",   32'(arbiter_cmd_out), 32'h0);
    chk("to_pre_grant", 32'(m_grant), 32'h2);
    step(1);
    chk("to_cmd",   32'(arbiter_cmd_out), 32'h1);
    chk("to_grant0", 32'(m_grant), 32'h0);
    chk("to_state", 32'(arb_state), 32'h3);
    m_request = 4'b0000;
    step(1);
    chk("to_cmd_width", 32'(arbiter_cmd_out), 32'h0);
    chk("to_idle", 32'(arb_state), 32'h0);

    // Hold limit 15 with HOLD_LEN=4, then rotation moves past the aborted owner.
    m_request = 4'b0110;
    step(1);
    chk("hd_grant", 32'(m_grant), 32'h4);
    b_util = 1'b1;
    step(1);
    chk("hd_busy", 32'(arb_state), 32'h2);
    step(15);
    chk("hd_still_busy", 32'(arb_state), 32'h2);
    step(1);
    chk("hd_abort_state", 32'(arb_state), 32'h4);
    chk("hd_abort_grant", 32'(m_grant), 32'h4);
    step(1);
    chk("hd_cmd",    32'(arbiter_cmd_out), 32'h1);
    chk("hd_grant0", 32'(m_grant), 32'h0);
    b_util = 1'b0;
    step(1);
    chk("hd_cmd_width", 32'(arbiter_cmd_out), 32'h0);
    chk("hd_idle", 32'(arb_state), 32'h0);
    step(1);
    chk("hd_next_grant", 32'(m_grant), 32'h2);
    chk("hd_next_owner", 32'(owner_id), 32'h1);

    // Asynchronous reset during BUSY.
    b_util = 1'b1;
    step(1);
    chk("ar_busy", 32'(arb_state), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_grant", 32'(m_grant), 32'h0);
    chk("ar_cmd",   32'(arbiter_cmd_out), 32'h0);
    chk("ar_owner", 32'(owner_id), 32'h0);
    chk("ar_bbusy", 32'(bus_busy), 32'h0);
    chk("ar_state", 32'(arb_state), 32'h0);
    b_util    = 1'b0;
    m_request = 4'b1001;
    step(1);
    chk("ar_held", 32'(m_grant), 32'h0);
    rstn = 1'b1;
    step(1);
    chk("ar_first_grant", 32'(m_grant), 32'h1);
    chk("ar_first_owner", 32'(owner_id), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
